vrom_bus_arb: RTL
=================

VROM_BUS_ARB -- requirements
Module: vrom_bus_arb

Interface
REQ-001 SHALL have parameter OE_CYCLES, default 2, number of cycles nROE is held low per access; legal range 1..15.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port REQ_A  input  1  ADPCM-A fetch request; level, held until ACK_A.
REQ-005 SHALL have port ADDR_A  input  24  ADPCM-A byte address.
REQ-006 SHALL have port REQ_B  input  1  ADPCM-B fetch request; level, held until ACK_B.
REQ-007 SHALL have port ADDR_B  input  24  ADPCM-B byte address.
REQ-008 SHALL have port ACK_A / ACK_B  output  1 each  one-cycle completion pulses.
REQ-009 SHALL have port DATA  output  8  last byte read from the V ROM.
REQ-010 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port RAD_OUT  output  8  multiplexed address byte driven onto RAD.
REQ-012 SHALL have port RAD_OE  output  1  RAD driver enable; RAD is tristated when low.
REQ-013 SHALL have port RAD_IN  input  8  RAD bus read-back.
REQ-014 SHALL have port RA_L  output  2  address bits [9:8] or [19:18] depending on phase.
REQ-015 SHALL have port RA_U  output  4  address bits [23:20].
REQ-016 SHALL have port RMPX  output  1  address latch strobe: rising edge latches address bits [9:0]; falling edge latches [23:10].
REQ-017 SHALL have port nROE  output  1  V ROM output enable, active low.

Function
REQ-018 All outputs SHALL be registered, and each SHALL be a function of the current state and the latched address only (Moore outputs).
REQ-019 The FSM SHALL have the states IDLE, AL, AL_STB, AH, AH_STB, RD and DONE.
- Each state lasts one cycle, except RD, which lasts OE_CYCLES cycles.
REQ-020 IDLE behaviour:
- If any request is high, the FSM SHALL grant one requester, latch that requester's address into ADDR_Q, record the grant in LAST, and go to AL.
- Otherwise it SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin:
- If only one request is high, that requester is granted.
- If both are high, the requester not recorded in LAST is granted.
REQ-022 AL: RAD_OE=1, RAD_OUT=ADDR_Q[7:0], RA_L=ADDR_Q[9:8], RMPX=0.
REQ-023 AL_STB: RAD_OUT and RA_L as in AL, RMPX=1 (rising edge latches bits [9:0]).
REQ-024 AH: RAD_OUT=ADDR_Q[17:10], RA_L=ADDR_Q[19:18], RMPX=1.
REQ-025 AH_STB: RAD_OUT and RA_L as in AH, RMPX=0 (falling edge latches bits [23:10]).
REQ-026 RA_U SHALL equal ADDR_Q[23:20] in every state from AL through DONE.
REQ-027 RD: RAD_OE=0, nROE=0, RMPX=0, for exactly OE_CYCLES cycles, counted by a 4-bit down-counter.
REQ-028 On the clock edge that ends the last RD cycle, DATA SHALL capture RAD_IN; DATA SHALL hold that value until the next capture.
REQ-029 DONE:
- nROE=1 and RAD_OE=0.
- The ACK of the granted requester is high for this single cycle.
- The next state is IDLE.
REQ-030 Latency: if a request is first seen in IDLE at cycle 0, the ACK SHALL be high in cycle 5+OE_CYCLES; back-to-back accesses SHALL occur every 6+OE_CYCLES cycles.
REQ-031 Request inputs SHALL be ignored in every state except IDLE.
- A request dropped mid-access does not abort the access; its ACK is still issued.
REQ-032 Address inputs SHALL be sampled only at grant; later changes to ADDR_A or ADDR_B do not affect an access already in progress.
REQ-033 ACK_A and ACK_B SHALL never be high in the same cycle.
REQ-034 RAD_OE and nROE=0 SHALL never be active in the same cycle.

Reset
REQ-035 RESET high SHALL immediately force the following, including in the middle of an access:
- state=IDLE, LAST=B (so A wins the first tie), ADDR_Q=0, counter=0.
- DATA=0x00, ACK_A=ACK_B=0, BUSY=0.
- RAD_OUT=0x00, RAD_OE=0, RA_L=0, RA_U=0, RMPX=0, nROE=1.
REQ-036 No access interrupted by reset SHALL be acknowledged after reset is released.

Verification
REQ-037 Single read: REQ_A=1, ADDR_A=0xABCDEF, OE_CYCLES=2, RAD_IN=0x5A during RD.
- RAD_OUT sequence is 0xEF,0xEF,0xF3,0xF3.
- RA_L sequence is 1,1,2,2; RA_U=0xA.
- RMPX sequence is 0,1,1,0.
- nROE is low for 2 cycles.
- ACK_A is high in cycle 7 with DATA=0x5A.
REQ-038 Tie, with both requests held and reset just released: grant order is A,B,A,B; ACK pulses are spaced 8 cycles apart; ACK_A and ACK_B never overlap.
REQ-039 Latch model: a behavioural model of the RMPX edge latches rebuilds the 24-bit address exactly.
- Test addresses: 0x000000, 0xFFFFFF, 0x3FF400.
REQ-040 Reset mid-operation: assert RESET during RD.
- All outputs take their reset values in the same cycle.
- No ACK appears after release.
- A new REQ_B is then served normally.
REQ-041 Request withdrawal: drop REQ_B during AH and change ADDR_B.
- The access completes with the originally latched address.
- ACK_B is issued.
- The FSM returns to IDLE.
REQ-042 Parameter sweep: OE_CYCLES=1 and OE_CYCLES=15 give ACK latencies of 6 and 20 cycles.
- RAD_OE and nROE are never active together.

Source files
------------

// File: rtl/vrom_bus_arb.sv
// vrom_bus_arb: round-robin arbiter between the ADPCM-A and ADPCM-B sample
// fetchers for a single multiplexed V ROM bus. One access runs through a
// fixed sequence: low address phase with RMPX strobe, high address phase
// with RMPX strobe, a read window of OE_CYCLES cycles with nROE low, then a
// one-cycle ACK to the requester that was granted.
//
// Every output is registered. The output registers are loaded from the
// *next* state and *next* latched address, so what is visible during a cycle
// always corresponds to the state register during that same cycle.

module vrom_bus_arb #(
   parameter int unsigned OE_CYCLES = 2   // nROE low time per access, 1..15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ_A,
   input  logic [23:0] ADDR_A,
   input  logic        REQ_B,
   input  logic [23:0] ADDR_B,
   output logic        ACK_A,
   output logic        ACK_B,
   output logic [7:0]  DATA,
   output logic        BUSY,
   output logic [7:0]  RAD_OUT,
   output logic        RAD_OE,
   input  logic [7:0]  RAD_IN,
   output logic [1:0]  RA_L,
   output logic [3:0]  RA_U,
   output logic        RMPX,
   output logic        nROE
);

   // ------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_AL     = 3'd1;
   localparam logic [2:0] ST_AL_STB = 3'd2;
   localparam logic [2:0] ST_AH     = 3'd3;
   localparam logic [2:0] ST_AH_STB = 3'd4;
   localparam logic [2:0] ST_RD     = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   // LAST encoding: which requester received the most recent grant
   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   // The down-counter starts at OE_CYCLES-1 so that the cycle in which it
   // reads zero is the final RD cycle.
   localparam logic [3:0] RD_LOAD = 4'(OE_CYCLES - 1);

   // ------------------------------------------------------------------
   // Core state
   // ------------------------------------------------------------------
   logic [2:0]  state_q, state_d;
   logic [23:0] addr_q,  addr_d;
   logic        last_q,  last_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [7:0]  data_d;
   logic        grant_b;

   // ------------------------------------------------------------------
   // Next-value of every output register
   // ------------------------------------------------------------------
   logic        ack_a_d;
   logic        ack_b_d;
   logic        busy_d;
   logic [7:0]  rad_out_d;
   logic        rad_oe_d;
   logic [1:0]  ra_l_d;
   logic [3:0]  ra_u_d;
   logic        rmpx_d;
   logic        nroe_d;

   // Next-state, arbitration, address latch, read counter and data capture
   always_comb begin
      // NOTE: every signal assigned here receives a default first, so no path
      // through the case statement leaves one unassigned and infers a latch.
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      data_d  = DATA;
      grant_b = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (REQ_A || REQ_B) begin
               // B wins only when it is alone, or when both are asking and A
               // was the one served last.
               grant_b = REQ_B && (!REQ_A || (last_q == GRANT_A));
               last_d  = grant_b ? GRANT_B : GRANT_A;
               addr_d  = grant_b ? ADDR_B : ADDR_A;
               state_d = ST_AL;
            end
         end

         ST_AL:     state_d = ST_AL_STB;
         ST_AL_STB: state_d = ST_AH;
         ST_AH:     state_d = ST_AH_STB;

         ST_AH_STB: begin
            state_d = ST_RD;
            cnt_d   = RD_LOAD;
         end

         ST_RD: begin
            if (cnt_q == 4'd0) begin
               // Last cycle of the read window: the ROM output has had the
               // full OE time to settle, so sample it on this edge.
               state_d = ST_DONE;
               data_d  = RAD_IN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_DONE:   state_d = ST_IDLE;

         default:   state_d = ST_IDLE;
      endcase
   end

   // Moore output decode from the upcoming state and latched address
   always_comb begin
      rad_out_d = 8'h00;
      rad_oe_d  = 1'b0;
      ra_l_d    = 2'b00;
      ra_u_d    = 4'h0;
      rmpx_d    = 1'b0;
      nroe_d    = 1'b1;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;
      busy_d    = (state_d != ST_IDLE);

      // The top nibble is not multiplexed, it is held for the whole access.
      if (state_d != ST_IDLE) begin
         ra_u_d = addr_d[23:20];
      end

      case (state_d)
         ST_AL: begin
            rad_oe_d  = 1'b1;
            rad_out_d = addr_d[7:0];
            ra_l_d    = addr_d[9:8];
            rmpx_d    = 1'b0;
         end

         ST_AL_STB: begin
            // RMPX rises here: external latch captures bits [9:0]
            rad_oe_d  = 1'b1;
            rad_out_d = addr_d[7:0];
            ra_l_d    = addr_d[9:8];
            rmpx_d    = 1'b1;
         end

         ST_AH: begin
            rad_oe_d  = 1'b1;
            rad_out_d = addr_d[17:10];
            ra_l_d    = addr_d[19:18];
            rmpx_d    = 1'b1;
         end

         ST_AH_STB: begin
            // RMPX falls here: external latch captures bits [23:10]
            rad_oe_d  = 1'b1;
            rad_out_d = addr_d[17:10];
            ra_l_d    = addr_d[19:18];
            rmpx_d    = 1'b0;
         end

         ST_RD: begin
            // RAD driver released before the ROM is enabled onto the bus
            rad_oe_d  = 1'b0;
            nroe_d    = 1'b0;
         end

         ST_DONE: begin
            ack_a_d   = (last_d == GRANT_A);
            ack_b_d   = (last_d == GRANT_B);
         end

         default: begin
            nroe_d    = 1'b1;
         end
      endcase
   end

   // State, latched address, round-robin history and read counter
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         addr_q  <= 24'h000000;
         last_q  <= GRANT_B;       // A wins the first tie after reset
         cnt_q   <= 4'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of block order.
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Registered bus, handshake and data outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         DATA    <= 8'h00;
         ACK_A   <= 1'b0;
         ACK_B   <= 1'b0;
         BUSY    <= 1'b0;
         RAD_OUT <= 8'h00;
         RAD_OE  <= 1'b0;
         RA_L    <= 2'b00;
         RA_U    <= 4'h0;
         RMPX    <= 1'b0;
         nROE    <= 1'b1;
      end else begin
         DATA    <= data_d;
         ACK_A   <= ack_a_d;
         ACK_B   <= ack_b_d;
         BUSY    <= busy_d;
         RAD_OUT <= rad_out_d;
         RAD_OE  <= rad_oe_d;
         RA_L    <= ra_l_d;
         RA_U    <= ra_u_d;
         RMPX    <= rmpx_d;
         nROE    <= nroe_d;
      end
   end

endmodule
